// File: rtl/execute_cycle.sv
// Purpose: RV32I EX stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency: PCSrcE/PCTargetE combinational; the EX/MEM register is 1 cycle, async active-high reset.
// Backpressure: none; the stage captures every cycle, and ID/EX flush supplies the bubbles.
// Optional: define EXEC_PERF_CNT_EN to add the perf_redirect_cnt / perf_exec_cnt counters.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic            luiE,
    input  logic [2:0]      ALUControlE,
    input  logic [2:0]      ResultSrcE,
    input  logic [1:0]      JumpE,
    input  logic [4:0]      RdE,
    input  logic [4:0]      RS1E,
    input  logic [4:0]      RS2E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] InstrE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [2:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] InstrM
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]     perf_redirect_cnt,
    output logic [31:0]     perf_exec_cnt
`endif
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            is_utype;
    logic            branch_cond;
    logic            is_jump;

    // Source register indices are only consumed by the hazard unit upstream.
    logic unused_rs;
    assign unused_rs = ^{RS1E, RS2E};

    // Operand forwarding: register file, write-back result, or this stage's own registered result.
    always_comb begin
        fwd_a = RD1E;
        fwd_b = RD2E;
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUResultM;
            default: fwd_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end

    // ALU operand select; lui/auipc override SrcA with zero or the PC.
    always_comb begin
        is_utype = (InstrE[6:0] == 7'b0110111) || (InstrE[6:0] == 7'b0010111);
        if (is_utype) begin
            src_a = luiE ? '0 : PCE;
        end else begin
            src_a = fwd_a;
        end
        src_b = ALUSrcE ? ImmExtE : fwd_b;
    end

    // ALU: all results XLEN wide, shifts use the low five bits of SrcB.
    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_result = src_a << src_b[4:0];
            default: alu_result = src_a >> src_b[4:0];
        endcase
    end

    // Branch condition compares the forwarded registers, never the immediate-muxed SrcB.
    always_comb begin
        branch_cond = 1'b0;
        case (InstrE[14:12])
            3'b000:  branch_cond = (fwd_a == fwd_b);
            3'b001:  branch_cond = (fwd_a != fwd_b);
            3'b100:  branch_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  branch_cond = (fwd_a < fwd_b);
            3'b111:  branch_cond = (fwd_a >= fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end

    // Redirect decision and target; jalr clears bit 0 of the computed address.
    always_comb begin
        is_jump   = (JumpE == 2'b01) || (JumpE == 2'b10);
        PCSrcE    = (BranchE & branch_cond) | is_jump;
        if (JumpE == 2'b10) begin
            PCTargetE = (fwd_a + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // EX/MEM pipeline register, captured every cycle; reset discards the in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            InstrM     <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
            InstrM     <= InstrE;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    // Event counters: redirects taken and non-bubble instructions, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirect_cnt <= '0;
            perf_exec_cnt     <= '0;
        end else begin
            if (PCSrcE) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
            if (InstrE != '0) begin
                perf_exec_cnt <= perf_exec_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Purpose: self-checking bench for execute_cycle: directed test-plan cases, then random traffic.
// Latency: compares PCSrcE/PCTargetE in the same cycle and the EX/MEM outputs one cycle later.
// Backpressure: none; a new input set is driven every cycle on the falling edge.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, BranchE, ALUSrcE, luiE;
    logic [2:0]  ALUControlE, ResultSrcE;
    logic [1:0]  JumpE, ForwardAE, ForwardBE;
    logic [4:0]  RdE, RS1E, RS2E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, InstrE, ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [2:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_redirect_cnt, perf_exec_cnt;
    logic [31:0] m_redir, m_exec;
`endif

    int checks = 0;
    int errors = 0;

    // Reference copy of the EX/MEM register contents.
    logic        m_rw, m_mw;
    logic [2:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4, m_instr;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .luiE(luiE), .ALUControlE(ALUControlE),
        .ResultSrcE(ResultSrcE), .JumpE(JumpE), .RdE(RdE), .RS1E(RS1E), .RS2E(RS2E),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .InstrE(InstrE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .InstrM(InstrM)
`ifdef EXEC_PERF_CNT_EN
        , .perf_redirect_cnt(perf_redirect_cnt), .perf_exec_cnt(perf_exec_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return rf;
    endfunction

    // Reference model of the combinational behaviour, using wide integer arithmetic.
    task automatic model(output bit taken, output logic [31:0] target,
                         output logic [31:0] alu, output logic [31:0] fb);
        logic [31:0] fa, sa, sb;
        longint unsigned a, b;
        bit cond;
        fa = pick(ForwardAE, RD1E);
        fb = pick(ForwardBE, RD2E);
        if (InstrE[6:0] == 7'h37 || InstrE[6:0] == 7'h17) sa = luiE ? 32'd0 : PCE;
        else sa = fa;
        sb = ALUSrcE ? ImmExtE : fb;
        a = longint'(sa);
        b = longint'(sb);
        case (ALUControlE)
            3'd0: alu = 32'((a + b) % 64'h1_0000_0000);
            3'd1: alu = 32'((a + 64'h1_0000_0000 - b) % 64'h1_0000_0000);
            3'd2: alu = sa & sb;
            3'd3: alu = sa | sb;
            3'd4: alu = sa ^ sb;
            3'd5: alu = (int'(sa) < int'(sb)) ? 32'd1 : 32'd0;
            3'd6: alu = 32'((a << (b % 32)) % 64'h1_0000_0000);
            default: alu = 32'(a >> (b % 32));
        endcase
        case (InstrE[14:12])
            3'd0: cond = (fa == fb);
            3'd1: cond = (fa != fb);
            3'd4: cond = (int'(fa) < int'(fb));
            3'd5: cond = (int'(fa) >= int'(fb));
            3'd6: cond = (longint'(fa) < longint'(fb));
            3'd7: cond = (longint'(fa) >= longint'(fb));
            default: cond = 1'b0;
        endcase
        taken = (BranchE && cond) || JumpE == 2'd1 || JumpE == 2'd2;
        if (JumpE == 2'd2) target = 32'(((longint'(fa) + longint'(ImmExtE)) / 2) * 2);
        else target = 32'(longint'(PCE) + longint'(ImmExtE));
    endtask

    task automatic clear_model();
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_instr = 0;
`ifdef EXEC_PERF_CNT_EN
        m_redir = 0; m_exec = 0;
`endif
    endtask

    task automatic check_m(input string tag);
        chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(m_rw));
        chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'(m_mw));
        chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(m_rs));
        chk({tag, ".RdM"}, 32'(RdM), 32'(m_rd));
        chk({tag, ".ALUResultM"}, ALUResultM, m_alu);
        chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
        chk({tag, ".PCPlus4M"}, PCPlus4M, m_pc4);
        chk({tag, ".InstrM"}, InstrM, m_instr);
`ifdef EXEC_PERF_CNT_EN
        chk({tag, ".perf_redirect"}, perf_redirect_cnt, m_redir);
        chk({tag, ".perf_exec"}, perf_exec_cnt, m_exec);
`endif
    endtask

    task automatic bubble();
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0; luiE = 0;
        ALUControlE = 0; ResultSrcE = 0; JumpE = 0; RdE = 0; RS1E = 0; RS2E = 0;
        RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0; InstrE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // Called just after a falling edge with inputs driven: checks combinational
    // outputs, clocks once, then checks the registered outputs.
    task automatic step(input string tag);
        bit tk;
        logic [31:0] tg, alu, fb;
        #1;
        model(tk, tg, alu, fb);
        chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(tk));
        chk({tag, ".PCTargetE"}, PCTargetE, tg);
        @(posedge clk);
        m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RdE;
        m_alu = alu; m_wd = fb; m_pc4 = PCPlus4E; m_instr = InstrE;
`ifdef EXEC_PERF_CNT_EN
        if (tk) m_redir = m_redir + 32'd1;
        if (InstrE != 0) m_exec = m_exec + 32'd1;
`endif
        #1;
        check_m(tag);
        @(negedge clk);
    endtask

    // Asserts reset between edges: registered outputs must clear without a clock edge.
    task automatic mid_reset();
        bit tk;
        logic [31:0] tg, alu, fb;
        #2 rst = 1'b1;
        #1;
        clear_model();
        check_m("rst_async");
        model(tk, tg, alu, fb);
        chk("rst_comb.PCSrcE", 32'(PCSrcE), 32'(tk));
        #1 rst = 1'b0;
        @(negedge clk);
        bubble();
        step("post_rst_bubble");
        chk("post_rst.PCSrcE_zero", 32'(PCSrcE), 32'd0);
    endtask

    task automatic randomize_inputs();
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); BranchE = 1'($urandom);
        ALUSrcE = 1'($urandom); luiE = 1'($urandom); ALUControlE = 3'($urandom);
        ResultSrcE = 3'($urandom); JumpE = 2'($urandom); RdE = 5'($urandom);
        RS1E = 5'($urandom); RS2E = 5'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        PCE = $urandom & 32'hFFFF_FFFC; PCPlus4E = PCE + 32'd4;
        ImmExtE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        ResultW = $urandom; InstrE = $urandom;
        case ($urandom_range(0, 7))
            0: InstrE[6:0] = 7'h37;
            1: InstrE[6:0] = 7'h17;
            2: bubble();
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        clear_model();
        #2;
        check_m("reset");
        @(negedge clk);
        rst = 1'b0;

        // add with forwarding from M: first produce 7, then 5 -> fwd(7) + 3 = 10
        bubble(); InstrE = 32'h0000_0013; ALUSrcE = 1; RD1E = 4; ImmExtE = 3; RegWriteE = 1; RdE = 5'd3;
        step("add_seed");
        chk("add_seed.value", ALUResultM, 32'd7);
        RD1E = 5; ForwardAE = 2'b10; PCPlus4E = 32'h104;
        step("add_fwd_m");
        chk("add_fwd_m.value", ALUResultM, 32'd10);

        // beq / bne with equal operands
        bubble(); BranchE = 1; RD1E = 9; RD2E = 9; PCE = 32'h100; ImmExtE = 32'h20; InstrE = 32'h0000_0063;
        #1;
        chk("beq.taken", 32'(PCSrcE), 32'd1);
        chk("beq.target", PCTargetE, 32'h120);
        step("beq");
        InstrE = 32'h0000_1063;
        #1;
        chk("bne.not_taken", 32'(PCSrcE), 32'd0);
        step("bne");

        // jalr
        bubble(); JumpE = 2'b10; RD1E = 32'h2003; ImmExtE = 4; InstrE = 32'h0000_0067;
        PCPlus4E = 32'h0000_0ABC; RegWriteE = 1; RdE = 5'd1;
        #1;
        chk("jalr.target", PCTargetE, 32'h2006);
        chk("jalr.taken", 32'(PCSrcE), 32'd1);
        step("jalr");
        chk("jalr.PCPlus4M", PCPlus4M, 32'h0000_0ABC);

        // lui / auipc
        bubble(); InstrE = 32'h1234_5037; luiE = 1; ALUSrcE = 1; ImmExtE = 32'h1234_5000; RD1E = 32'hDEAD_BEEF;
        step("lui");
        chk("lui.value", ALUResultM, 32'h1234_5000);
        InstrE = 32'h1234_5017; luiE = 0; PCE = 32'h40;
        step("auipc");
        chk("auipc.value", ALUResultM, 32'h1234_5040);

        // signed vs unsigned compares: -1 vs 1
        bubble(); BranchE = 1; RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'b101; InstrE = 32'h0000_4063;
        #1;
        chk("blt.taken", 32'(PCSrcE), 32'd1);
        step("blt");
        chk("slt.value", ALUResultM, 32'd1);
        InstrE = 32'h0000_6063;
        #1;
        chk("bltu.not_taken", 32'(PCSrcE), 32'd0);
        step("bltu");

        // reset mid-stream with a live instruction in flight
        bubble(); RegWriteE = 1; MemWriteE = 1; RdE = 5'd7; RD1E = 32'h55; ImmExtE = 1; ALUSrcE = 1;
        InstrE = 32'h0070_0393;
        step("pre_rst");
        randomize_inputs();
        mid_reset();

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i % 97 == 50) mid_reset();
            else step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
EX stage of the 5-stage RV32I pipeline, directly downstream of the ID/EX register.
- Forwards operands using the hazard unit's selects, then executes the ALU operation.
- Resolves branches and jumps, producing the PC redirect for fetch.
- Registers results into the EX/MEM pipeline register consumed by the memory stage.

Parameters:
XLEN, 32, datapath width (fixed at 32 for RV32I; no other value supported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
RegWriteE  input  1  register write enable from ID/EX
MemWriteE  input  1  store enable
BranchE  input  1  conditional branch instruction
ALUSrcE  input  1  1: SrcB = ImmExtE; 0: SrcB = forwarded rs2
luiE  input  1  U-type select: 1 = lui (SrcA = 0), 0 = auipc (SrcA = PCE)
ALUControlE  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
ResultSrcE  input  3  write-back source select, passed through unchanged
JumpE  input  2  00 none, 01 jal, 10 jalr, 11 reserved (treated as none)
RdE, RS1E, RS2E  input  5 each  destination and source register indices
RD1E, RD2E  input  32 each  register file operands
PCE, PCPlus4E, ImmExtE, InstrE  input  32 each  PC, PC+4, extended immediate, instruction word
ForwardAE, ForwardBE  input  2 each  00 register file value, 01 ResultW, 10 ALUResultM, 11 register file value
ResultW  input  32  write-back result, forwarding source
PCSrcE  output  1  redirect fetch (combinational)
PCTargetE  output  32  redirect target (combinational)
RegWriteM, MemWriteM  output  1 each  registered controls
ResultSrcM  output  3  registered write-back source select
RdM  output  5  registered destination index
ALUResultM, WriteDataM, PCPlus4M, InstrM  output  32 each  registered ALU result, store data, PC+4, instruction

Behaviour:
- Forwarding:
  - FwdA = mux(ForwardAE: RD1E, ResultW, ALUResultM).
  - FwdB = the same mux using ForwardBE and RD2E.
  - ALUResultM here is the registered output of this block.
- U-type detection: InstrE[6:0] is 0110111 or 0010111. If U-type, SrcA = luiE ? 0 : PCE; otherwise SrcA = FwdA.
- SrcB = ALUSrcE ? ImmExtE : FwdB.
- ALU operations:
  - add/sub: modulo 2^32.
  - slt: signed compare, result 32'd1 or 32'd0.
  - sll/srl: shift amount SrcB[4:0], logical, zero-fill.
  - All results are 32-bit.
- Branch compare always uses FwdA against FwdB, not SrcB. Condition by InstrE[14:12]:
  - 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
  - 010 and 011 never take the branch.
- PCSrcE = (BranchE & cond) | JumpE==01 | JumpE==10. Purely combinational, no latency.
- PCTargetE: JumpE==10 gives (FwdA + ImmExtE) & ~32'h1; otherwise PCE + ImmExtE.
- Bubble input (all controls 0, InstrE 0): PCSrcE = 0, and nothing is written downstream.
- EX/MEM register:
  - Captures on every rising clk, 1-cycle latency.
  - Fields: RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M, InstrM; WriteDataM = FwdB.
  - No stall or flush inputs: MEM and WB never stall, and ID/EX flush supplies the bubbles.
- Reset: all registered outputs go to 0 immediately on rst assertion, independent of clk. A reset mid-instruction discards it.
- Combinational outputs follow their inputs during reset.
- x0: no special handling here. RegWriteE is already cleared for Rd = 0 upstream.

Optional Feature:
Macro EXEC_PERF_CNT_EN.
- When defined, two added outputs:
  - perf_redirect_cnt (32): increments each clk on which PCSrcE = 1.
  - perf_exec_cnt (32): increments each clk on which InstrE != 0.
- Both counters reset to 0 asynchronously, wrap 32'hFFFFFFFF -> 0, and are visible 1 cycle after the event.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- add, forward from M: RD1E = 5, ForwardAE = 10, ALUResultM = 7, SrcB imm = 3, ALUControlE = 000 -> ALUResultM = 10 next cycle, PCSrcE = 0.
- beq vs bne, operands 9 and 9, PCE = 0x100, ImmExtE = 0x20 -> beq: PCSrcE = 1, PCTargetE = 0x120; bne (funct3 001): PCSrcE = 0.
- jalr: FwdA = 0x2003, ImmExtE = 4, JumpE = 10 -> PCTargetE = 0x2006, PCSrcE = 1, PCPlus4M = PCPlus4E next cycle.
- lui/auipc: InstrE opcode 0110111, luiE = 1, ImmExtE = 0x12345000 -> ALUResultM = 0x12345000; opcode 0010111, luiE = 0, PCE = 0x40 -> ALUResultM = 0x12345040.
- Signed compares: FwdA = 0xFFFFFFFF, FwdB = 1 -> blt taken, bltu not taken, slt = 1.
- Reset mid-stream: assert rst between clk edges -> all M outputs become 0 before the next edge; after release, a bubble input gives PCSrcE = 0 and RegWriteM = 0.
